maxpool_row_ctrl: RTL and testbench



---
 rtl/maxpool_row_ctrl.sv | 120 ++++++++++++
 tb/tb_maxpool_row_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_row_ctrl.sv
// Row sequencer for 2x2 max pooling: pairs incoming rows for the pooling datapath,
// registers each pooled row behind a valid/ready stage and tracks frame progress.
module maxpool_row_ctrl #(
    parameter int DATA_BITS = 32,
    parameter int D         = 1,
    parameter int H         = 48,
    parameter int W         = 48,
    localparam int ROW_BITS     = W * D * DATA_BITS,
    localparam int POOL_BITS    = (W / 2) * D * DATA_BITS,
    localparam int CNT_BITS     = $clog2(H + 1),
    localparam int OUT_ROW_BITS = (H / 2 > 0) ? $clog2(H / 2 + 1) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    row_valid_i,
    output logic                    row_ready_o,
    input  logic [ROW_BITS-1:0]     row_data_i,
    output logic                    pool_valid_o,
    output logic [ROW_BITS-1:0]     pool_data_o,
    input  logic                    pool_valid_i,
    input  logic [POOL_BITS-1:0]    pool_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [POOL_BITS-1:0]    out_data_o,
    output logic [OUT_ROW_BITS-1:0] out_row_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam bit ODD_H = (H % 2) == 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                  state;
    logic [CNT_BITS-1:0]     row_cnt;
    logic                    parity;
    logic [OUT_ROW_BITS-1:0] pooled_cnt;

    logic last_row;
    logic forward;
    logic accept;
    logic drain;

    // The last row of an odd-height frame has no partner, so it is swallowed
    // without touching parity and without waiting on the output stage.
    assign last_row     = (row_cnt == CNT_BITS'(H - 1));
    assign forward      = !(ODD_H && last_row);
    assign row_ready_o  = (state == RUN) && (!parity || !forward || !out_valid_o || out_ready_i);
    assign accept       = row_valid_i && row_ready_o;
    assign pool_valid_o = accept && forward;
    assign pool_data_o  = row_data_i;
    assign drain        = out_valid_o && out_ready_i;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            row_cnt <= '0;
            parity  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= RUN;
                        row_cnt <= '0;
                        parity  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        row_cnt <= row_cnt + CNT_BITS'(1);
                        if (forward) begin
                            parity <= !parity;
                        end
                        if (last_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_o || drain) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A capture wins over a drain in the same cycle, so out_valid_o stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_row_o   <= '0;
            pooled_cnt  <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                pooled_cnt <= '0;
            end
            if (pool_valid_i) begin
                out_valid_o <= 1'b1;
                out_data_o  <= pool_data_i;
                out_row_o   <= pooled_cnt;
                pooled_cnt  <= pooled_cnt + OUT_ROW_BITS'(1);
            end else if (drain) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_row_ctrl.sv
// Directed bench for maxpool_row_ctrl: three instances (H=4, H=5, H=1) share one stimulus
// stream, each fed by a small behavioural model of the pooling datapath.
module tb_maxpool_row_ctrl;

    localparam int DB = 8;
    localparam int W  = 4;

    localparam logic [31:0] R0 = 32'h04_03_02_01;
    localparam logic [31:0] R1 = 32'h10_01_01_05;
    localparam logic [31:0] R2 = 32'h20_30_40_50;
    localparam logic [31:0] R3 = 32'h01_02_03_04;
    localparam logic [31:0] R4 = 32'hFF_FF_FF_FF;

    typedef struct {
        int          reps;
        logic        rst;
        logic        st;
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic [22:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        row_valid = 1'b0;
    logic [31:0] row_data = '0;
    logic        out_ready = 1'b0;
    logic        inject4 = 1'b0;

    int checks = 0;
    int errors = 0;
    int proto_err4 = 0;
    int proto_err5 = 0;

    logic        rr4, pvo4, pvi4, ov4, busy4, done4;
    logic [31:0] pdo4;
    logic [15:0] pdi4, od4;
    logic [1:0]  orow4;
    logic        rr5, pvo5, pvi5, ov5, busy5, done5;
    logic [31:0] pdo5;
    logic [15:0] pdi5, od5;
    logic [1:0]  orow5;
    logic        rr1, pvo1, ov1, busy1, done1;
    logic [31:0] pdo1;
    logic [15:0] od1;
    logic [0:0]  orow1;

    logic [22:0] stat4, stat5, stat1;
    assign stat4 = {rr4, pvo4, ov4, od4, orow4, busy4, done4};
    assign stat5 = {rr5, pvo5, ov5, od5, orow5, busy5, done5};
    assign stat1 = {rr1, pvo1, ov1, od1, 1'b0, orow1, busy1, done1};

    always #5 clk = ~clk;

    maxpool_row_ctrl #(.DATA_BITS(DB), .D(1), .H(4), .W(W)) dut4 (
        .clk(clk), .reset(reset), .start_i(start), .row_valid_i(row_valid), .row_ready_o(rr4),
        .row_data_i(row_data), .pool_valid_o(pvo4), .pool_data_o(pdo4), .pool_valid_i(pvi4),
        .pool_data_i(pdi4), .out_valid_o(ov4), .out_ready_i(out_ready), .out_data_o(od4),
        .out_row_o(orow4), .busy_o(busy4), .done_o(done4)
    );

    maxpool_row_ctrl #(.DATA_BITS(DB), .D(1), .H(5), .W(W)) dut5 (
        .clk(clk), .reset(reset), .start_i(start), .row_valid_i(row_valid), .row_ready_o(rr5),
        .row_data_i(row_data), .pool_valid_o(pvo5), .pool_data_o(pdo5), .pool_valid_i(pvi5),
        .pool_data_i(pdi5), .out_valid_o(ov5), .out_ready_i(out_ready), .out_data_o(od5),
        .out_row_o(orow5), .busy_o(busy5), .done_o(done5)
    );

    maxpool_row_ctrl #(.DATA_BITS(DB), .D(1), .H(1), .W(W)) dut1 (
        .clk(clk), .reset(reset), .start_i(start), .row_valid_i(row_valid), .row_ready_o(rr1),
        .row_data_i(row_data), .pool_valid_o(pvo1), .pool_data_o(pdo1), .pool_valid_i(1'b0),
        .pool_data_i(16'h0000), .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
        .out_row_o(orow1), .busy_o(busy1), .done_o(done1)
    );

    function automatic logic [15:0] pool2(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] m;
        pool2 = '0;
        for (int j = 0; j < 2; j++) begin
            m = a[16*j +: 8];
            if (a[16*j+8 +: 8] > m) m = a[16*j+8 +: 8];
            if (b[16*j +: 8] > m) m = b[16*j +: 8];
            if (b[16*j+8 +: 8] > m) m = b[16*j+8 +: 8];
            pool2[8*j +: 8] = m;
        end
    endfunction

    // Behavioural pooling datapath: holds the first row of a pair, answers on the second.
    logic [31:0] dp_row4, dp_row5;
    logic        dp_par4, dp_par5;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_row4 <= '0;
            dp_par4 <= 1'b0;
            dp_row5 <= '0;
            dp_par5 <= 1'b0;
        end else begin
            if (pvo4) begin
                if (!dp_par4) dp_row4 <= pdo4;
                dp_par4 <= !dp_par4;
            end
            if (pvo5) begin
                if (!dp_par5) dp_row5 <= pdo5;
                dp_par5 <= !dp_par5;
            end
        end
    end

    assign pvi4 = (pvo4 && dp_par4) || inject4;
    assign pdi4 = pool2(dp_row4, pdo4);
    assign pvi5 = pvo5 && dp_par5;
    assign pdi5 = pool2(dp_row5, pdo5);

    // Protocol monitor: a pooled result may only arrive alongside a forwarded odd row.
    always @(posedge clk) begin
        if (!reset && pvi4 && !(pvo4 && dut4.parity)) proto_err4 <= proto_err4 + 1;
        if (!reset && pvi5 && !(pvo5 && dut5.parity)) proto_err5 <= proto_err5 + 1;
    end

    function automatic vec_t mk(input int reps, input logic rst, input logic st, input logic v,
                                input logic [31:0] d, input logic rdy, input logic [2:0] hs,
                                input logic [15:0] od, input logic [1:0] orow, input logic [1:0] bd);
        vec_t x;
        x.reps = reps;
        x.rst  = rst;
        x.st   = st;
        x.v    = v;
        x.d    = d;
        x.rdy  = rdy;
        x.exp  = {hs, od, orow, bd};
        return x;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (stat4 !== 23'h0) begin errors++; $display("[TB] FAIL reset_h4: got %h, expected %h", stat4, 23'h0); end
        checks++;
        if (stat5 !== 23'h0) begin errors++; $display("[TB] FAIL reset_h5: got %h, expected %h", stat5, 23'h0); end
        checks++;
        if (stat1 !== 23'h0) begin errors++; $display("[TB] FAIL reset_h1: got %h, expected %h", stat1, 23'h0); end
    endtask

    task automatic test_back_to_back();
        vec_t tbl[$];
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, R0, 1, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R1, 1, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R2, 1, 3'b111, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R3, 1, 3'b110, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b001, 16'h3050, 1, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h3050, 1, 2'b01));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h3050, 1, 2'b00));
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                @(posedge clk); #1;
                reset = tbl[i].rst; start = tbl[i].st; row_valid = tbl[i].v;
                row_data = tbl[i].d; out_ready = tbl[i].rdy;
                @(negedge clk);
                checks++;
                if (stat4 !== tbl[i].exp) begin
                    errors++;
                    $display("[TB] FAIL back_to_back step %0d: got %h, expected %h", i, stat4, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic test_odd_height();
        vec_t tbl[$];
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        for (int f = 0; f < 2; f++) begin
            logic [15:0] stale_d;
            logic [1:0]  stale_r;
            stale_d = (f == 0) ? 16'h0000 : 16'h3050;
            stale_r = (f == 0) ? 2'd0 : 2'd1;
            tbl.push_back(mk(1, 0, 1, 0, 0,  1, 3'b000, stale_d, stale_r, 2'b00));
            tbl.push_back(mk(1, 0, 0, 1, R0, 1, 3'b110, stale_d, stale_r, 2'b10));
            tbl.push_back(mk(1, 0, 0, 1, R1, 1, 3'b110, stale_d, stale_r, 2'b10));
            tbl.push_back(mk(1, 0, 0, 1, R2, 1, 3'b111, 16'h1005, 0, 2'b10));
            tbl.push_back(mk(1, 0, 0, 1, R3, 1, 3'b110, 16'h1005, 0, 2'b10));
            tbl.push_back(mk(1, 0, 0, 1, R4, 1, 3'b101, 16'h3050, 1, 2'b10));
            tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h3050, 1, 2'b10));
            tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h3050, 1, 2'b01));
        end
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                @(posedge clk); #1;
                reset = tbl[i].rst; start = tbl[i].st; row_valid = tbl[i].v;
                row_data = tbl[i].d; out_ready = tbl[i].rdy;
                @(negedge clk);
                checks++;
                if (stat5 !== tbl[i].exp) begin
                    errors++;
                    $display("[TB] FAIL odd_height step %0d: got %h, expected %h", i, stat5, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic test_backpressure_drain();
        vec_t tbl[$];
        tbl.push_back(mk(1,  1, 0, 0, 0,  0, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1,  0, 1, 0, 0,  0, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1,  0, 0, 1, R0, 0, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1,  0, 0, 1, R1, 0, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1,  0, 0, 1, R2, 0, 3'b111, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(10, 0, 0, 1, R3, 0, 3'b001, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(1,  0, 0, 1, R3, 1, 3'b111, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(2,  0, 0, 0, 0,  0, 3'b001, 16'h3050, 1, 2'b10));
        tbl.push_back(mk(1,  0, 0, 0, 0,  1, 3'b001, 16'h3050, 1, 2'b10));
        tbl.push_back(mk(1,  0, 0, 0, 0,  0, 3'b000, 16'h3050, 1, 2'b01));
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                @(posedge clk); #1;
                reset = tbl[i].rst; start = tbl[i].st; row_valid = tbl[i].v;
                row_data = tbl[i].d; out_ready = tbl[i].rdy;
                @(negedge clk);
                checks++;
                if (stat4 !== tbl[i].exp) begin
                    errors++;
                    $display("[TB] FAIL backpressure step %0d.%0d: got %h, expected %h", i, r, stat4, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic test_start_and_reset();
        vec_t tbl[$];
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 1, R0, 1, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 1, 1, R1, 1, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 1, 1, R2, 1, 3'b111, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(1, 0, 1, 1, R3, 1, 3'b110, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b001, 16'h3050, 1, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h3050, 1, 2'b01));
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 3'b000, 16'h3050, 1, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, R0, 1, 3'b110, 16'h3050, 1, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R1, 1, 3'b110, 16'h3050, 1, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R2, 1, 3'b111, 16'h1005, 0, 2'b10));
        tbl.push_back(mk(1, 1, 0, 1, R3, 1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, R2, 1, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R3, 1, 3'b110, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R0, 1, 3'b111, 16'h3050, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 1, R1, 1, 3'b110, 16'h3050, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b001, 16'h1005, 1, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h1005, 1, 2'b01));
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                @(posedge clk); #1;
                reset = tbl[i].rst; start = tbl[i].st; row_valid = tbl[i].v;
                row_data = tbl[i].d; out_ready = tbl[i].rdy;
                @(negedge clk);
                checks++;
                if (stat4 !== tbl[i].exp) begin
                    errors++;
                    $display("[TB] FAIL start_reset step %0d: got %h, expected %h", i, stat4, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic test_single_row();
        vec_t tbl[$];
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        tbl.push_back(mk(1, 0, 0, 1, R1, 1, 3'b100, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b01));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b000, 16'h0000, 0, 2'b00));
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                @(posedge clk); #1;
                reset = tbl[i].rst; start = tbl[i].st; row_valid = tbl[i].v;
                row_data = tbl[i].d; out_ready = tbl[i].rdy;
                @(negedge clk);
                checks++;
                if (stat1 !== tbl[i].exp) begin
                    errors++;
                    $display("[TB] FAIL single_row step %0d: got %h, expected %h", i, stat1, tbl[i].exp);
                end
            end
        end
    endtask

    task automatic test_protocol_injection();
        checks++;
        if ((proto_err4 + proto_err5) !== 0) begin
            errors++;
            $display("[TB] FAIL protocol_clean: got %0d violations, expected 0", proto_err4 + proto_err5);
        end
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0; row_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; row_valid = 1'b1; row_data = R0; inject4 = 1'b1;
        @(posedge clk); #1;
        row_valid = 1'b0; inject4 = 1'b0;
        @(negedge clk);
        checks++;
        if (proto_err4 !== 1) begin
            errors++;
            $display("[TB] FAIL protocol_inject: got %0d violations, expected 1", proto_err4);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        $display("[TB] maxpool_row_ctrl directed tests");
        test_reset();
        test_back_to_back();
        test_odd_height();
        test_backpressure_drain();
        test_start_and_reset();
        test_single_row();
        test_protocol_injection();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
